// File: rtl/rvbridge_pkg.sv
// Shared constants for the raw/VIP bridge blocks.
// Default widths used by the FIFO monitor and by other bridge logic live here.
package rvbridge_pkg;

    localparam int RVB_USEDW_W    = 15;
    localparam int RVB_NUM_CH     = 2;
    localparam int RVB_WIN_W      = 24;
    localparam int RVB_CH_SLICE_W = RVB_USEDW_W;
    localparam int RVB_MAX_CH     = 16;

endpackage

// File: rtl/rvbridge_fifo_mon_ch.sv
// One channel of the FIFO monitor: running max/min, window peak and sticky threshold alarm.
// The window terminal strobe and clear come from the shared counter in the top level.
module rvbridge_fifo_mon_ch
    import rvbridge_pkg::*;
#(
    parameter int USEDW_WIDTH = RVB_CH_SLICE_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [USEDW_WIDTH-1:0] usedw,
    input  logic                   clr,
    input  logic                   term,
    input  logic [USEDW_WIDTH-1:0] thresh,
    output logic [USEDW_WIDTH-1:0] maxusedw,
    output logic [USEDW_WIDTH-1:0] minusedw,
    output logic [USEDW_WIDTH-1:0] winpeak,
    output logic                   alarm
);

    function automatic logic [USEDW_WIDTH-1:0] umax(input logic [USEDW_WIDTH-1:0] a,
                                                    input logic [USEDW_WIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [USEDW_WIDTH-1:0] umin(input logic [USEDW_WIDTH-1:0] a,
                                                    input logic [USEDW_WIDTH-1:0] b);
        return (a < b) ? a : b;
    endfunction

    logic [USEDW_WIDTH-1:0] run_pk;
    logic                   hit;

    assign hit = (thresh != '0) && (usedw >= thresh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            maxusedw <= '0;
            minusedw <= '1;
            winpeak  <= '0;
            run_pk   <= '0;
            alarm    <= 1'b0;
        end else begin
            if (clr) begin
                maxusedw <= usedw;
                minusedw <= usedw;
            end else begin
                maxusedw <= umax(usedw, maxusedw);
                minusedw <= umin(usedw, minusedw);
            end
            // The terminal sample itself belongs to the closing window.
            if (term)
                winpeak <= umax(run_pk, usedw);
            run_pk <= (clr || term) ? '0 : umax(run_pk, usedw);
            // A fresh hit outranks a simultaneous clear.
            alarm  <= hit | (alarm & ~clr);
        end
    end

endmodule

// File: rtl/rvbridge_fifo_monitor.sv
// Multi-channel FIFO fill-level monitor with shared measurement window.
// Owns the window counter and win_valid; per-channel statistics live in rvbridge_fifo_mon_ch.
module rvbridge_fifo_monitor
    import rvbridge_pkg::*;
#(
    parameter int USEDW_WIDTH = RVB_CH_SLICE_W,
    parameter int NUM_CH      = RVB_NUM_CH,
    parameter int WIN_WIDTH   = RVB_WIN_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CH*USEDW_WIDTH-1:0] usedw,
    input  logic                          clr,
    input  logic [USEDW_WIDTH-1:0]        thresh,
    input  logic [WIN_WIDTH-1:0]          win_period,
    output logic [NUM_CH*USEDW_WIDTH-1:0] maxusedw,
    output logic [NUM_CH*USEDW_WIDTH-1:0] minusedw,
    output logic [NUM_CH*USEDW_WIDTH-1:0] winpeak,
    output logic                          win_valid,
    output logic [NUM_CH-1:0]             alarm
);

    localparam logic [WIN_WIDTH-1:0] WIN_ONE = WIN_WIDTH'(1);

    logic [WIN_WIDTH-1:0] win_cnt;
    logic                 term;

    // Compare against the live period so shrinking it mid-window ends the window at once.
    assign term = !clr && (win_period != '0) && (win_cnt >= (win_period - WIN_ONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt   <= '0;
            win_valid <= 1'b0;
        end else begin
            win_valid <= term;
            if (clr || term || (win_period == '0))
                win_cnt <= '0;
            else
                win_cnt <= win_cnt + WIN_ONE;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        rvbridge_fifo_mon_ch #(
            .USEDW_WIDTH(USEDW_WIDTH)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .usedw    (usedw[k*USEDW_WIDTH +: USEDW_WIDTH]),
            .clr      (clr),
            .term     (term),
            .thresh   (thresh),
            .maxusedw (maxusedw[k*USEDW_WIDTH +: USEDW_WIDTH]),
            .minusedw (minusedw[k*USEDW_WIDTH +: USEDW_WIDTH]),
            .winpeak  (winpeak[k*USEDW_WIDTH +: USEDW_WIDTH]),
            .alarm    (alarm[k])
        );
    end

endmodule
